apb_regfile_bridge: RTL and testbench
=====================================

# apb_regfile_bridge

APB slave that converts bus transfers into the single write port and single read port of the generated register file, and sits directly upstream of it. Each valid transfer becomes exactly one cycle of register-file write or read activity. Read data is registered before it is returned. Misaligned or out-of-range accesses are rejected with PSLVERR and never reach the register file, so read-clear registers are only cleared by legitimate reads.

## Interface
Parameters:
- ADDR_WIDTH, 8, register-file address width (byte address)
- DATA_WIDTH, 32, data width; must be a multiple of 8
- ADDR_MAX, 8'h24, highest mapped word address; anything above it is an error
- PARK_ADDR, 8'hFC, unmapped address driven on rf_rd_addr when no read is in progress

Ports (clk and rst_n are the only clock and reset: one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  1 = write transfer
- paddr  in  ADDR_WIDTH  byte address
- pwdata  in  DATA_WIDTH  write data
- pstrb  in  DATA_WIDTH/8  byte strobes; present only with the macro
- prdata  out  DATA_WIDTH  registered read data
- pready  out  1  transfer complete
- pslverr  out  1  error response; valid only while pready=1
- rf_wr_en  out  1  one-cycle register-file write strobe
- rf_wr_addr  out  ADDR_WIDTH  write address
- rf_wr_data  out  DATA_WIDTH  write data
- rf_wr_be  out  DATA_WIDTH/8  byte enables
- rf_rd_addr  out  ADDR_WIDTH  read address; PARK_ADDR when idle
- rf_rd_data  in  DATA_WIDTH  combinational read data from the register file

## Operation
- States: IDLE, WR, RD, RESP.
- IDLE:
  - A setup phase is psel=1 and penable=0. On a setup phase the bridge latches paddr, pwrite, pwdata and pstrb, and evaluates err.
  - err = (paddr[1:0] != 0) OR (paddr > ADDR_MAX) OR (read AND pstrb != 0, macro builds only).
  - err=1 goes to RESP. Otherwise a write goes to WR and a read goes to RD.
  - penable=1 without a preceding setup phase is ignored.
- WR: rf_wr_en=1 for exactly one cycle, with the latched address, data and byte enables. Then go to RESP.
- RD: rf_rd_addr = latched address for exactly one cycle. prdata captures rf_rd_data at the end of that cycle. Then go to RESP.
- RESP:
  - pready=1 and pslverr=err.
  - prdata is forced to 0 when the transfer was an errored read.
  - If psel=1 and penable=1, the transfer completes and the state returns to IDLE.
  - If psel=0 (bus abort), return to IDLE.
- Abort during WR or RD: the one-cycle register-file action still happens, then the state returns to IDLE.
- Outputs outside their active state:
  - rf_wr_en=0.
  - rf_wr_addr, rf_wr_data and rf_wr_be hold their last latched values.
  - rf_rd_addr=PARK_ADDR.
  - pready=0 and pslverr=0.
  - prdata holds its last value.
- Reset values: state IDLE, prdata=0, pready=0, pslverr=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, rf_wr_be=0, rf_rd_addr=PARK_ADDR.

## Timing
- Cycle C0 is the setup phase; latching happens at the end of C0.
- Valid transfer:
  - C1 is WR or RD, with pready=0 (one wait state).
  - C2 is RESP, with pready=1.
  - For a write, the register-file contents update at the end of C1.
  - For a read, prdata is valid from C2.
- Errored transfer: C1 is RESP (zero wait states). No register-file activity occurs.
- Back-to-back transfers: a setup phase in the cycle after RESP is accepted. The minimum is 3 cycles per valid transfer.
- Assertion of rst_n=0 at any time, including mid-transfer, forces reset values immediately. An interrupted write either completed at a prior edge or never occurred; no partial writes.

## Configuration
- APB_REGFILE_BRIDGE_PSTRB_EN defined:
  - The pstrb port exists and rf_wr_be = latched pstrb.
  - A read with nonzero pstrb is an error.
- Undefined:
  - The pstrb port is absent and rf_wr_be is all ones on every write.
  - Reads are never rejected for strobes.

## Structure
- Package apb_regfile_bridge_pkg holds:
  - the state enum typedef (IDLE, WR, RD, RESP);
  - localparam defaults for ADDR_MAX and PARK_ADDR.
- One sub-module, apb_addr_check. It is combinational and takes paddr, pwrite and pstrb, and produces err. The top-level module holds the FSM and the registers.

## Test plan
- Write 0x00 with pwdata=0xDEADBEEF and pstrb=4'hF: rf_wr_en pulses once in C1 with addr 0x00 and be 4'hF; pready=1 and pslverr=0 in C2; a following read of 0x00 returns 0xDEADBEEF.
- Read 0x08 (read-clear register preloaded with 0x5): prdata=0x5 in C2 and rf_rd_addr=0x08 for exactly one cycle; a second read of 0x08 returns 0.
- Access 0x06 (misaligned) and 0x28 (above ADDR_MAX): pready=1 and pslverr=1 in C1; rf_wr_en stays 0; rf_rd_addr stays 0xFC; prdata=0 on the read.
- Partial write to 0x18 with pstrb=4'h2 and pwdata=0x0000AB00: rf_wr_be=4'h2. Without the macro, rf_wr_be=4'hF.
- Assert rst_n=0 in C1 of a read: pready, rf_wr_en and prdata are 0 immediately and rf_rd_addr=0xFC; the next transfer after reset completes normally.
- Drop psel during WR: exactly one rf_wr_en pulse, the state returns to IDLE, and no pready is issued.

Source files
------------

// File: rtl/apb_regfile_bridge_pkg.sv
// apb_regfile_bridge_pkg
//   Shared definitions for the APB-to-register-file bridge: the bridge FSM
//   state encoding and the default address-map constants used as parameter
//   defaults by apb_regfile_bridge and apb_addr_check.
package apb_regfile_bridge_pkg;

  // Bridge FSM states: wait for setup, one write-port cycle, one read-port
  // cycle, and the APB response phase.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Highest mapped word address of the register file.
  localparam logic [7:0] ADDR_MAX_DEFAULT  = 8'h24;
  // Unmapped address presented on the read port while no read is active,
  // so read-clear registers never see a spurious access.
  localparam logic [7:0] PARK_ADDR_DEFAULT = 8'hFC;

endpackage

// File: rtl/apb_addr_check.sv
// apb_addr_check
//   Combinational access checker. Flags a transfer that must be rejected with
//   PSLVERR instead of reaching the register file.
//   Optional feature macro: APB_REGFILE_BRIDGE_PSTRB_EN (adds the strobe rule
//   and the pwrite/pstrb inputs it needs).
// Ports:
//   paddr   in  byte address of the setup phase
//   pwrite  in  transfer direction (macro builds only)
//   pstrb   in  byte strobes (macro builds only)
//   err     out 1 = misaligned, above ADDR_MAX, or read with nonzero strobes
module apb_addr_check
  import apb_regfile_bridge_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MAX   = ADDR_WIDTH'(ADDR_MAX_DEFAULT)
`ifdef APB_REGFILE_BRIDGE_PSTRB_EN
  ,
  parameter int                    STRB_WIDTH = 4
`endif
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
`ifdef APB_REGFILE_BRIDGE_PSTRB_EN
  input  logic                  pwrite,
  input  logic [STRB_WIDTH-1:0] pstrb,
`endif
  output logic                  err
);

  // Error decode: any single rule is enough to reject the access.
  always_comb begin
    err = 1'b0;
    if (paddr[1:0] != 2'b00) begin
      err = 1'b1;
    end else if (paddr > ADDR_MAX) begin
      err = 1'b1;
`ifdef APB_REGFILE_BRIDGE_PSTRB_EN
    end else if (!pwrite && (pstrb != {STRB_WIDTH{1'b0}})) begin
      // A read carrying strobes is malformed APB.
      err = 1'b1;
`endif
    end else begin
      err = 1'b0;
    end
  end

endmodule

// File: rtl/apb_regfile_bridge.sv
// apb_regfile_bridge
//   APB slave in front of the generated register file. Every accepted transfer
//   becomes exactly one cycle on the register-file write port or read port;
//   rejected transfers (see apb_addr_check) never touch the register file, so
//   read-clear registers are only cleared by legitimate reads.
//   Optional feature macro: APB_REGFILE_BRIDGE_PSTRB_EN (pstrb port, byte
//   enables taken from pstrb, reads with strobes rejected). Without it every
//   write enables all bytes.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   psel, penable       APB select / enable
//   pwrite, paddr       direction, byte address
//   pwdata, pstrb       write data, byte strobes (pstrb with macro only)
//   prdata              registered read data (0 after an errored read)
//   pready, pslverr     transfer complete / error response
//   rf_wr_en            one-cycle register-file write strobe
//   rf_wr_addr/data/be  register-file write address, data, byte enables
//   rf_rd_addr          register-file read address, PARK_ADDR when idle
//   rf_rd_data          combinational register-file read data
// All outputs come straight from flops.
module apb_regfile_bridge
  import apb_regfile_bridge_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MAX   = ADDR_WIDTH'(ADDR_MAX_DEFAULT),
  parameter logic [ADDR_WIDTH-1:0] PARK_ADDR  = ADDR_WIDTH'(PARK_ADDR_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_REGFILE_BRIDGE_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic                    rf_wr_en,
  output logic [ADDR_WIDTH-1:0]   rf_wr_addr,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic [DATA_WIDTH/8-1:0] rf_wr_be,
  output logic [ADDR_WIDTH-1:0]   rf_rd_addr,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_e                  state_q,      state_d;
  logic [DATA_WIDTH-1:0]   prdata_q,     prdata_d;
  logic                    pready_q,     pready_d;
  logic                    pslverr_q,    pslverr_d;
  logic                    rf_wr_en_q,   rf_wr_en_d;
  logic [ADDR_WIDTH-1:0]   rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic [STRB_WIDTH-1:0]   rf_wr_be_q,   rf_wr_be_d;
  logic [ADDR_WIDTH-1:0]   rf_rd_addr_q, rf_rd_addr_d;

  logic                    setup;
  logic                    addr_err;
  logic [STRB_WIDTH-1:0]   wr_be;

  assign setup = psel && !penable;

`ifdef APB_REGFILE_BRIDGE_PSTRB_EN
  assign wr_be = pstrb;
`else
  assign wr_be = {STRB_WIDTH{1'b1}};
`endif

  apb_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR_MAX   (ADDR_MAX)
`ifdef APB_REGFILE_BRIDGE_PSTRB_EN
    ,
    .STRB_WIDTH (STRB_WIDTH)
`endif
  ) u_addr_check (
    .paddr  (paddr),
`ifdef APB_REGFILE_BRIDGE_PSTRB_EN
    .pwrite (pwrite),
    .pstrb  (pstrb),
`endif
    .err    (addr_err)
  );

  // Next-state and next-output logic. Outputs are registered, so each *_d is
  // the value the output carries in the state being entered.
  always_comb begin
    state_d      = state_q;
    prdata_d     = prdata_q;
    pready_d     = 1'b0;
    pslverr_d    = 1'b0;
    rf_wr_en_d   = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    rf_wr_be_d   = rf_wr_be_q;
    rf_rd_addr_d = PARK_ADDR;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          if (addr_err) begin
            // Zero-wait error response; the register file is never touched.
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            if (!pwrite) begin
              prdata_d = {DATA_WIDTH{1'b0}};
            end else begin
              prdata_d = prdata_q;
            end
          end else if (pwrite) begin
            state_d      = ST_WR;
            rf_wr_en_d   = 1'b1;
            rf_wr_addr_d = paddr;
            rf_wr_data_d = pwdata;
            rf_wr_be_d   = wr_be;
          end else begin
            state_d      = ST_RD;
            rf_rd_addr_d = paddr;
          end
        end else begin
          // Includes penable without a setup phase, which is ignored.
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        // The write strobe already fired this cycle; an abort skips RESP.
        if (psel) begin
          state_d  = ST_RESP;
          pready_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        prdata_d = rf_rd_data;
        if (psel) begin
          state_d  = ST_RESP;
          pready_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (!psel || penable) begin
          state_d = ST_IDLE;
        end else begin
          // Master not yet in its access phase: keep the response up.
          state_d   = ST_RESP;
          pready_d  = 1'b1;
          pslverr_d = pslverr_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prdata_q     <= {DATA_WIDTH{1'b0}};
      pready_q     <= 1'b0;
      pslverr_q    <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= {ADDR_WIDTH{1'b0}};
      rf_wr_data_q <= {DATA_WIDTH{1'b0}};
      rf_wr_be_q   <= {STRB_WIDTH{1'b0}};
      rf_rd_addr_q <= PARK_ADDR;
    end else begin
      state_q      <= state_d;
      prdata_q     <= prdata_d;
      pready_q     <= pready_d;
      pslverr_q    <= pslverr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_wr_be_q   <= rf_wr_be_d;
      rf_rd_addr_q <= rf_rd_addr_d;
    end
  end

  assign prdata     = prdata_q;
  assign pready     = pready_q;
  assign pslverr    = pslverr_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign rf_wr_be   = rf_wr_be_q;
  assign rf_rd_addr = rf_rd_addr_q;

endmodule

// File: tb/tb_apb_regfile_bridge.sv
// tb_apb_regfile_bridge
//   Self-checking bench for apb_regfile_bridge: directed scenarios followed by
//   randomized APB transfers, checked against a word-level reference model of
//   the register file contents. A separate behavioural register file (with a
//   read-clear register at 0x08) answers the bridge's read port.
`timescale 1ns/1ps
module tb_apb_regfile_bridge;

  localparam int         AW   = 8;
  localparam int         DW   = 32;
  localparam int         SW   = DW / 8;
  localparam logic [7:0] PARK = 8'hFC;
  localparam logic [7:0] AMAX = 8'h24;
`ifdef APB_REGFILE_BRIDGE_PSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
`ifdef APB_REGFILE_BRIDGE_PSTRB_EN
  logic [SW-1:0] pstrb;
`endif
  logic [DW-1:0] prdata;
  logic          pready, pslverr, rf_wr_en;
  logic [AW-1:0] rf_wr_addr, rf_rd_addr;
  logic [DW-1:0] rf_wr_data, rf_rd_data;
  logic [SW-1:0] rf_wr_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_regfile_bridge dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
`ifdef APB_REGFILE_BRIDGE_PSTRB_EN
    .pstrb      (pstrb),
`endif
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .rf_wr_be   (rf_wr_be),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data)
  );

  // Behavioural register file: 16 words, word 2 (0x08) is read-clear.
  logic [31:0] env_mem [0:15];
  logic        env_init;

  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= (i == 2) ? 32'h5 : 32'h0;
    end else begin
      if (rf_wr_en && rf_wr_addr <= 8'h3C) begin
        for (int b = 0; b < SW; b++)
          if (rf_wr_be[b]) env_mem[rf_wr_addr[5:2]][8*b +: 8] <= rf_wr_data[8*b +: 8];
      end
      if (rf_rd_addr == 8'h08) env_mem[2] <= 32'h0;
    end
  end

  assign rf_rd_data = (rf_rd_addr <= 8'h3C) ? env_mem[rf_rd_addr[5:2]] : 32'hBAD0_BAD0;

  // Register-file activity counters, sampled mid-cycle.
  int wr_pulses = 0;
  int rd_cycles = 0;
  always @(negedge clk) begin
    if (rf_wr_en) wr_pulses <= wr_pulses + 1;
    if (rf_rd_addr != PARK) rd_cycles <= rd_cycles + 1;
  end

  // Reference model: expected contents of the ten mapped words.
  logic [31:0] ref_mem [0:9];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_err(input logic wr, input logic [7:0] a, input logic [3:0] s);
    logic e;
    e = ((a % 4) != 0) || (a > AMAX);
    if (STRB_EN && !wr && s != 4'h0) e = 1'b1;
    return e;
  endfunction

  // One complete APB transfer starting with its setup phase now.
  // abort=1 drops psel in the cycle after setup.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic abort);
    int          wp0, rc0, idx;
    logic        err;
    logic [31:0] expd;
    logic [3:0]  ebe;
    err  = exp_err(wr, a, s);
    ebe  = STRB_EN ? s : 4'hF;
    idx  = a / 4;
    expd = 32'h0;
    wp0  = wr_pulses;
    rc0  = rd_cycles;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
`ifdef APB_REGFILE_BRIDGE_PSTRB_EN
    pstrb = s;
`endif
    check("idle_pready", pready, 1'b0);
    step();
    if (abort) begin
      psel = 1'b0; penable = 1'b0;
    end else begin
      penable = 1'b1;
    end
    if (err) begin
      check("err_pready", pready, 1'b1);
      check("err_pslverr", pslverr, 1'b1);
      check("err_wr_en", rf_wr_en, 1'b0);
      check("err_rd_addr", rf_rd_addr, PARK);
      if (!wr) check("err_prdata", prdata, 32'h0);
    end else begin
      check("c1_pready", pready, 1'b0);
      if (wr) begin
        check("wr_en", rf_wr_en, 1'b1);
        check("wr_addr", rf_wr_addr, a);
        check("wr_data", rf_wr_data, d);
        check("wr_be", rf_wr_be, ebe);
        check("wr_rd_addr_park", rf_rd_addr, PARK);
        for (int b = 0; b < 4; b++)
          if (ebe[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        check("rd_addr", rf_rd_addr, a);
        check("rd_wr_en", rf_wr_en, 1'b0);
        expd = ref_mem[idx];
        if (a == 8'h08) ref_mem[idx] = 32'h0;
      end
      step();
      if (abort) begin
        check("abort_pready", pready, 1'b0);
      end else begin
        check("c2_pready", pready, 1'b1);
        check("c2_pslverr", pslverr, 1'b0);
        check("c2_wr_en", rf_wr_en, 1'b0);
        check("c2_rd_addr", rf_rd_addr, PARK);
        if (!wr) check("rd_prdata", prdata, expd);
      end
    end
    step();
    psel = 1'b0; penable = 1'b0;
    check("wr_pulses", wr_pulses - wp0, (!err && wr) ? 1 : 0);
    check("rd_cycles", rd_cycles - rc0, (!err && !wr) ? 1 : 0);
  endtask

  // Watchdog: the bench is cycle-scripted, this only guards against a stall.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        wr, ab;
    int          cls;
    rst_n = 1'b0; env_init = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0; pwdata = 32'h0;
`ifdef APB_REGFILE_BRIDGE_PSTRB_EN
    pstrb = 4'h0;
`endif
    for (int i = 0; i < 10; i++) ref_mem[i] = (i == 2) ? 32'h5 : 32'h0;
    repeat (3) step();
    check("rst_pready", pready, 1'b0);
    check("rst_pslverr", pslverr, 1'b0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_wr_en", rf_wr_en, 1'b0);
    check("rst_wr_addr", rf_wr_addr, 8'h0);
    check("rst_wr_data", rf_wr_data, 32'h0);
    check("rst_wr_be", rf_wr_be, 4'h0);
    check("rst_rd_addr", rf_rd_addr, PARK);
    env_init = 1'b0;
    rst_n    = 1'b1;
    step();

    // Directed scenarios.
    xfer(1'b1, 8'h00, 32'hDEADBEEF, 4'hF, 1'b0);
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
    xfer(1'b0, 8'h08, 32'h0, 4'h0, 1'b0);
    xfer(1'b0, 8'h08, 32'h0, 4'h0, 1'b0);
    xfer(1'b1, 8'h06, 32'h11111111, 4'hF, 1'b0);
    xfer(1'b0, 8'h06, 32'h0, 4'h0, 1'b0);
    xfer(1'b0, 8'h28, 32'h0, 4'h0, 1'b0);
    xfer(1'b1, 8'h28, 32'h22222222, 4'hF, 1'b0);
    xfer(1'b1, 8'h18, 32'h0000AB00, 4'h2, 1'b0);
    xfer(1'b0, 8'h18, 32'h0, 4'h0, 1'b0);
    xfer(1'b1, 8'h10, 32'h12345678, 4'hF, 1'b1);
    xfer(1'b0, 8'h10, 32'h0, 4'h0, 1'b0);
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 1'b0);

    // Reset in the read-port cycle of a read: outputs clear at once.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
    step();
    penable = 1'b1;
    check("rr_rd_addr_before", rf_rd_addr, 8'h04);
    #2 rst_n = 1'b0;
    #1;
    check("rr_pready", pready, 1'b0);
    check("rr_pslverr", pslverr, 1'b0);
    check("rr_wr_en", rf_wr_en, 1'b0);
    check("rr_prdata", prdata, 32'h0);
    check("rr_rd_addr", rf_rd_addr, PARK);
    psel = 1'b0; penable = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
    xfer(1'b1, 8'h24, 32'hCAFEF00D, 4'hF, 1'b0);
    xfer(1'b0, 8'h24, 32'h0, 4'h0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      cls = $urandom_range(0, 9);
      if (cls <= 5)      a = 8'($urandom_range(0, 9) * 4);
      else if (cls <= 7) a = 8'($urandom_range(0, 9) * 4 + $urandom_range(1, 3));
      else               a = 8'($urandom_range(10, 63) * 4);
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      if (wr || $urandom_range(0, 4) == 0) s = 4'($urandom_range(0, 15));
      else                                  s = 4'h0;
      ab = ($urandom_range(0, 9) == 0);
      xfer(wr, a, d, s, ab);
      repeat ($urandom_range(0, 1)) step();
    end

    // Final sweep: every mapped word matches the model.
    for (int i = 0; i < 10; i++) xfer(1'b0, 8'(i * 4), 32'h0, 4'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
